ring_counter_monitor: RTL and testbench
=======================================

Name: ring_counter_monitor

Overview:
- Receive-side checker for a one-hot ring counter: samples the counter's parallel output `q_in` and decodes the hot bit to a binary index.
- Validates legality (exactly one bit set) and sequence (each new sample is the rotate-left of the previous one).
- Tracks lock state and keeps a saturating error count.
- Sits beside any ring counter (behavioural or structural) as an in-system self-check and as the scoreboard in counter benches.

Parameters:
- WIDTH, 4, ring length / bit width of `q_in` (>= 2).
- LOCK_CNT, 2, consecutive correct transitions needed to declare lock (>= 1).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable; `q_in` is evaluated only on edges where en=1.
- q_in  input  WIDTH  ring counter output under observation.
- clr_err  input  1  synchronous clear of `err_count`.
- idx  output  $clog2(WIDTH)  binary position of the hot bit of the last sample.
- idx_valid  output  1  last sample was one-hot.
- locked  output  1  FSM in LOCKED.
- illegal  output  1  one-cycle pulse: sample was not one-hot.
- seq_err  output  1  one-cycle pulse: legal sample, wrong successor, while LOCKED.
- err_count  output  ERR_CNT_W  saturating count of illegal + seq_err events.

Behaviour:
- Reset (async, rst_n=0):
  - State = UNSYNC; prev, run, idx, err_count = 0.
  - idx_valid, locked, illegal, seq_err = 0.
  - Release is synchronous to the next clk edge by design intent; no internal synchronizer.
- All outputs are registered. Latency: sample on edge N (en=1) → flags/idx valid after edge N, i.e. 1 cycle.
- en=0 edge: no state change, idx/idx_valid/locked hold, illegal/seq_err forced 0.
- Legal = popcount(q_in)==1. All-zero and multi-hot values are illegal.
- expected = {prev[WIDTH-2:0], prev[WIDTH-1]} (rotate left). A held value counts as a mismatch.
- Legal sample: idx = position of the hot bit, idx_valid=1, prev <= q_in. Illegal sample: idx holds, idx_valid=0, prev unchanged.
- FSM (en=1 edges only):
  - UNSYNC: legal → ACQ, run=0. Illegal → stay, illegal pulse.
  - ACQ:
    - Illegal → UNSYNC, illegal pulse.
    - Legal && q_in==expected → run++; if run+1==LOCK_CNT → LOCKED.
    - Legal mismatch → stay, run=0 (re-anchor, no seq_err).
  - LOCKED:
    - Legal && match → stay.
    - Legal mismatch → ACQ, run=0, seq_err pulse.
    - Illegal → UNSYNC, illegal pulse.
- err_count:
  - +1 on each illegal or seq_err pulse, in any state.
  - Saturates at 2^ERR_CNT_W-1, no wrap.
  - clr_err=1 clears to 0 and wins over a same-cycle increment.
- Reset mid-operation: immediate return to reset values; lock is re-acquired from scratch.
- Wrap-around: MSB-hot → LSB-hot is a legal match (idx WIDTH-1 → 0).

Decomposition:
- Package ring_pkg:
  - State enum {UNSYNC, ACQ, LOCKED}.
  - Function rotl(vec) returning the one-step rotate-left.
  - Function is_onehot(vec).
- One sub-module: onehot_to_bin (combinational WIDTH → $clog2(WIDTH) encoder plus a valid output), reusable for Johnson counter decoders.
- FSM, prev register and counter stay in the top module.

Test Plan (WIDTH=4, LOCK_CNT=2 unless noted):
- Reset then en=1 with q_in 0001,0010,0100,1000,0001 → idx 0,1,2,3,0; idx_valid=1 throughout; locked=1 after the 0100 sample and held through the wrap to 0001; err_count=0.
- Locked, then q_in=0110 → illegal=1 for one cycle, idx_valid=0, locked=0, err_count=1. Next 1000 → ACQ, no pulse.
- Locked at 0001, then q_in=0100 (skip) → seq_err pulse, locked=0, err_count=1. Then 1000,0001 → locked=1 again.
- ERR_CNT_W=2, five illegal 0000 samples → err_count 1,2,3,3,3. clr_err asserted together with a 6th illegal → err_count=0.
- en=0 for 3 cycles while q_in changes arbitrarily → all outputs hold, no pulses. en=1 resumes checking against the pre-stall prev.
- rst_n dropped asynchronously mid-cycle while locked → locked, idx, err_count go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring counter monitor.
// Helpers take a wide vector plus the live width so any ring length up to MAX_W can reuse them.
package ring_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    if (w >= MAX_W) return '1;
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] vec, input int w);
    logic [MAX_W-1:0] v;
    v = vec & width_mask(w);
    return ((v << 1) | (v >> (w - 1))) & width_mask(w);
  endfunction

  function automatic logic is_onehot(input logic [MAX_W-1:0] vec, input int w);
    logic [MAX_W-1:0] v;
    v = vec & width_mask(w);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ring_counter_monitor_if.sv
// Observation bus of the ring counter monitor: sampled counter value in, status/flags out.
interface ring_counter_monitor_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic                 en;
  logic [WIDTH-1:0]     q_in;
  logic                 clr_err;
  logic [IDX_W-1:0]     idx;
  logic                 idx_valid;
  logic                 locked;
  logic                 illegal;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output en, q_in, clr_err,
    input  idx, idx_valid, locked, illegal, seq_err, err_count
  );

  modport slave (
    input  en, q_in, clr_err,
    output idx, idx_valid, locked, illegal, seq_err, err_count
  );
endinterface

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder; valid is high only for exactly one set bit.
module onehot_to_bin
  import ring_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // OR of set positions: exact for one-hot input, don't-care otherwise (valid qualifies it).
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = idx | IDX_W'(i);
    end
  end

  assign valid = is_onehot(MAX_W'(vec), WIDTH);

endmodule

// File: rtl/ring_counter_monitor.sv
// One-hot ring counter checker: decodes the hot bit, checks rotate-left succession,
// tracks lock and keeps a saturating error count.
//   state  | meaning
//   UNSYNC | no legal anchor sample yet
//   ACQ    | anchored, counting consecutive correct transitions
//   LOCKED | LOCK_CNT correct transitions seen; mismatches now flag seq_err
module ring_counter_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ring_counter_monitor_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  state_t               state;
  logic [WIDTH-1:0]     prev;
  logic [RUN_W-1:0]     run;
  logic [IDX_W-1:0]     idx_q;
  logic                 idx_valid_q;
  logic                 locked_q;
  logic                 illegal_q;
  logic                 seq_err_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic [IDX_W-1:0]     enc_idx;
  logic                 legal;
  logic [WIDTH-1:0]     expected;
  logic                 match;
  logic                 err_event;

  onehot_to_bin #(.WIDTH(WIDTH)) u_enc (
    .vec   (bus.q_in),
    .idx   (enc_idx),
    .valid (legal)
  );

  assign expected  = WIDTH'(rotl(MAX_W'(prev), WIDTH));
  assign match     = (bus.q_in == expected);
  assign err_event = bus.en && (!legal || (state == LOCKED && !match));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNSYNC;
      prev        <= '0;
      run         <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;

      if (bus.en) begin
        if (legal) begin
          idx_q       <= enc_idx;
          idx_valid_q <= 1'b1;
          prev        <= bus.q_in;
        end else begin
          idx_valid_q <= 1'b0;
        end

        if (!legal) begin
          state     <= UNSYNC;
          locked_q  <= 1'b0;
          illegal_q <= 1'b1;
        end else begin
          case (state)
            UNSYNC: begin
              state <= ACQ;
              run   <= '0;
            end
            ACQ: begin
              if (match) begin
                run <= run + RUN_W'(1);
                if (int'(run) + 1 == LOCK_CNT) begin
                  state    <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                run <= '0;
              end
            end
            LOCKED: begin
              if (!match) begin
                state     <= ACQ;
                run       <= '0;
                locked_q  <= 1'b0;
                seq_err_q <= 1'b1;
              end
            end
            default: begin
              state    <= UNSYNC;
              locked_q <= 1'b0;
            end
          endcase
        end
      end

      if (bus.clr_err)
        err_count_q <= '0;
      else if (err_event && err_count_q != '1)
        err_count_q <= err_count_q + ERR_CNT_W'(1);
    end
  end

  assign bus.idx       = idx_q;
  assign bus.idx_valid = idx_valid_q;
  assign bus.locked    = locked_q;
  assign bus.illegal   = illegal_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Directed bench for ring_counter_monitor: one 4-bit/8-bit-count instance for the main
// sequences and a 2-bit-count instance for saturation.
module tb_ring_counter_monitor;
  import ring_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ring_counter_monitor_if #(.WIDTH(4), .ERR_CNT_W(8)) bus_a ();
  ring_counter_monitor_if #(.WIDTH(4), .ERR_CNT_W(2)) bus_b ();

  ring_counter_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(8)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  ring_counter_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(2)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive unit A for one clock edge, then sample 1 time unit after the edge
  task automatic step_a(input logic e, input logic [3:0] q, input logic c);
    bus_a.en = e; bus_a.q_in = q; bus_a.clr_err = c;
    @(posedge clk); #1;
  endtask

  task automatic chk_a(input string tag, input int i, input int v, input int l,
                       input int il, input int se, input int ec);
    chk({tag, ".idx"},       32'(bus_a.idx),       32'(i));
    chk({tag, ".idx_valid"}, 32'(bus_a.idx_valid), 32'(v));
    chk({tag, ".locked"},    32'(bus_a.locked),    32'(l));
    chk({tag, ".illegal"},   32'(bus_a.illegal),   32'(il));
    chk({tag, ".seq_err"},   32'(bus_a.seq_err),   32'(se));
    chk({tag, ".err_count"}, 32'(bus_a.err_count), 32'(ec));
  endtask

  initial begin
    bus_a.en = 1'b0; bus_a.q_in = 4'b0000; bus_a.clr_err = 1'b0;
    bus_b.en = 1'b0; bus_b.q_in = 4'b0000; bus_b.clr_err = 1'b0;
    #1;
    chk_a("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_b.err_count", 32'(bus_b.err_count), 0);
    #11 rst_n = 1'b1;

    // clean rotation with wrap
    step_a(1, 4'b0001, 0); chk_a("rot0", 0, 1, 0, 0, 0, 0);
    step_a(1, 4'b0010, 0); chk_a("rot1", 1, 1, 0, 0, 0, 0);
    step_a(1, 4'b0100, 0); chk_a("rot2", 2, 1, 1, 0, 0, 0);
    step_a(1, 4'b1000, 0); chk_a("rot3", 3, 1, 1, 0, 0, 0);
    step_a(1, 4'b0001, 0); chk_a("wrap", 0, 1, 1, 0, 0, 0);

    // multi-hot while locked, then recovery
    step_a(1, 4'b0110, 0); chk_a("multihot", 0, 0, 0, 1, 0, 1);
    step_a(1, 4'b1000, 0); chk_a("reanchor", 3, 1, 0, 0, 0, 1);
    step_a(1, 4'b0001, 0); chk_a("acq1", 0, 1, 0, 0, 0, 1);
    step_a(1, 4'b0010, 0); chk_a("relock", 1, 1, 1, 0, 0, 1);
    step_a(1, 4'b0100, 0);
    step_a(1, 4'b1000, 0);
    step_a(1, 4'b0001, 0); chk_a("locked_at_0001", 0, 1, 1, 0, 0, 1);

    // clear with en=0: only err_count changes
    step_a(0, 4'b1111, 1); chk_a("clr_idle", 0, 1, 1, 0, 0, 0);

    // skipped position while locked
    step_a(1, 4'b0100, 0); chk_a("skip", 2, 1, 0, 0, 1, 1);
    step_a(1, 4'b1000, 0); chk_a("skip_acq", 3, 1, 0, 0, 0, 1);
    step_a(1, 4'b0001, 0); chk_a("skip_relock", 0, 1, 1, 0, 0, 1);

    // stall: outputs hold whatever q_in does
    step_a(0, 4'b1111, 0); chk_a("stall0", 0, 1, 1, 0, 0, 1);
    step_a(0, 4'b0000, 0); chk_a("stall1", 0, 1, 1, 0, 0, 1);
    step_a(0, 4'b0100, 0); chk_a("stall2", 0, 1, 1, 0, 0, 1);
    step_a(1, 4'b0010, 0); chk_a("resume", 1, 1, 1, 0, 0, 1);

    // held value is a sequence error
    step_a(1, 4'b0010, 0); chk_a("held", 1, 1, 0, 0, 1, 2);
    step_a(1, 4'b0100, 0); chk_a("held_acq", 2, 1, 0, 0, 0, 2);
    step_a(1, 4'b1000, 0); chk_a("held_relock", 3, 1, 1, 0, 0, 2);

    // asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1 chk_a("async_rst", 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    step_a(1, 4'b0001, 0); chk_a("post_rst0", 0, 1, 0, 0, 0, 0);
    step_a(1, 4'b0010, 0); chk_a("post_rst1", 1, 1, 0, 0, 0, 0);
    step_a(1, 4'b0100, 0); chk_a("post_rst2", 2, 1, 1, 0, 0, 0);
    step_a(0, 4'b0000, 0);

    // saturation on the 2-bit counter
    bus_b.en = 1'b1; bus_b.q_in = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat%0d.err_count", k), 32'(bus_b.err_count), (k < 3) ? k : 3);
      chk($sformatf("sat%0d.illegal", k), 32'(bus_b.illegal), 1);
    end
    bus_b.clr_err = 1'b1;
    @(posedge clk); #1;
    chk("sat_clr.err_count", 32'(bus_b.err_count), 0);
    chk("sat_clr.illegal", 32'(bus_b.illegal), 1);
    bus_b.clr_err = 1'b0; bus_b.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
